serial_mod_checker: RTL and testbench

Bit-serial divisibility checker: accepts one input bit per clock and tracks the running remainder of the bits received so far, modulo a parameter `MOD`. Bit order (LSB-first or MSB-first) is selected by parameter. Framing uses start, valid and last handshakes, so successive words can be checked back-to-back. This block is the parametrised successor of the team's fixed multiple-of-three serial detector and replaces it in the serial-arithmetic lab datapath.

---
 rtl/serial_mod_checker.sv | 129 ++++++++++++
 tb/tb_serial_mod_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mod_checker.sv
// serial_mod_checker: bit-serial divisibility checker.
// Tracks the running remainder, modulo MOD, of a framed serial word that arrives
// one bit per clock, either LSB-first or MSB-first. All arithmetic stays in
// RW+1 bits and uses a single conditional subtract, because every operand is
// already reduced below MOD.
`timescale 1ns/1ps

module serial_mod_checker #(
  parameter int MOD       = 3,
  parameter int MAX_BITS  = 16,
  parameter int LSB_FIRST = 1,
  localparam int RW = $clog2(MOD),
  localparam int CW = $clog2(MAX_BITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic          a,
  input  logic          in_last,
  output logic          b,
  output logic [RW-1:0] rem,
  output logic [CW-1:0] bit_cnt,
  output logic          done,
  output logic          ovf
);

  localparam logic [RW:0]   MOD_EXT = MOD[RW:0];
  localparam logic [CW-1:0] MAX_CNT = MAX_BITS[CW-1:0];
  localparam logic [RW-1:0] W_INIT  = RW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] w;
  logic [RW-1:0] rem_base;
  logic [RW-1:0] w_base;
  logic [RW-1:0] rem_nxt;
  logic [RW-1:0] w_nxt;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_base;
  logic          ovf_nxt;
  logic          b_nxt;
  logic [RW:0]   sum_t;
  logic [RW:0]   dbl_w;
  logic          accept;
  logic          take;

  // Frame state register; reset returns the checker to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame sequencing: start wins from any state, a valid last bit closes the frame.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_IDLE;
      ST_RUN: begin
        if (in_valid && in_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (start) begin
      state_nxt = (in_valid && in_last) ? ST_DONE : ST_RUN;
    end
  end

  // Remainder update: start clears the frame first, so a bit in the start cycle is bit 0.
  always_comb begin
    rem_base = start ? '0 : rem;
    w_base   = start ? W_INIT : w;
    cnt_base = start ? '0 : bit_cnt;
    ovf_base = start ? 1'b0 : ovf;
    accept   = in_valid && (start || (state == ST_RUN));
    take     = accept && (cnt_base < MAX_CNT);
    rem_nxt  = rem_base;
    w_nxt    = w_base;
    cnt_nxt  = cnt_base;
    ovf_nxt  = ovf_base;
    dbl_w    = {w_base, 1'b0};
    if (LSB_FIRST != 0) begin
      sum_t = {1'b0, rem_base} + (a ? {1'b0, w_base} : '0);
    end else begin
      sum_t = {rem_base, a};
    end
    if (take) begin
      rem_nxt = (sum_t >= MOD_EXT) ? RW'(sum_t - MOD_EXT) : sum_t[RW-1:0];
      if (LSB_FIRST != 0) begin
        w_nxt = (dbl_w >= MOD_EXT) ? RW'(dbl_w - MOD_EXT) : dbl_w[RW-1:0];
      end
      cnt_nxt = cnt_base + CW'(1);
    end else if (accept) begin
      ovf_nxt = 1'b1;
    end
    b_nxt = (rem_nxt == '0);
  end

  // Datapath registers; the empty word counts as divisible, so b resets to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      b       <= 1'b1;
      bit_cnt <= '0;
      w       <= W_INIT;
      ovf     <= 1'b0;
    end else begin
      rem     <= rem_nxt;
      b       <= b_nxt;
      bit_cnt <= cnt_nxt;
      w       <= w_nxt;
      ovf     <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_serial_mod_checker.sv
// tb_serial_mod_checker: drives several differently-parameterised checkers with
// one shared serial stream and compares each against a word-level model that
// keeps the frame's bits and reduces the whole word with %.
`timescale 1ns/1ps

module tb_serial_mod_checker;

  localparam int NI = 5;

  function automatic int cfg_mod(int i);
    case (i)
      0: return 3;
      1: return 5;
      2: return 7;
      3: return 3;
      default: return 11;
    endcase
  endfunction

  function automatic int cfg_max(int i);
    return (i == 3) ? 4 : 16;
  endfunction

  function automatic int cfg_lsb(int i);
    return (i == 1 || i == 4) ? 0 : 1;
  endfunction

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic a = 1'b0;
  logic in_last = 1'b0;

  logic [31:0] dut_rem  [NI];
  logic [31:0] dut_b    [NI];
  logic [31:0] dut_cnt  [NI];
  logic [31:0] dut_done [NI];
  logic [31:0] dut_ovf  [NI];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bit bits_m [NI][16];
  int n_m    [NI];
  bit ovf_m  [NI];
  bit done_m [NI];
  bit open_m [NI];

  // Free-running clock
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int M  = cfg_mod(g);
    localparam int MB = cfg_max(g);
    localparam int L  = cfg_lsb(g);
    logic [$clog2(M)-1:0]    r;
    logic [$clog2(MB+1)-1:0] c;
    logic bo;
    logic dn;
    logic ov;
    serial_mod_checker #(.MOD(M), .MAX_BITS(MB), .LSB_FIRST(L)) u_dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .a(a),
      .in_last(in_last), .b(bo), .rem(r), .bit_cnt(c), .done(dn), .ovf(ov)
    );
    assign dut_rem[g]  = 32'(r);
    assign dut_cnt[g]  = 32'(c);
    assign dut_b[g]    = 32'(bo);
    assign dut_done[g] = 32'(dn);
    assign dut_ovf[g]  = 32'(ov);
  end

  // Word value of the accepted bits, reduced modulo MOD
  function automatic int model_rem(int i);
    int v = 0;
    for (int k = 0; k < n_m[i]; k++) begin
      if (cfg_lsb(i) != 0) v = v + (int'(bits_m[i][k]) << k);
      else                 v = v * 2 + int'(bits_m[i][k]);
    end
    return v % cfg_mod(i);
  endfunction

  // Model: record the frame's bits at each rising edge
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        n_m[i] = 0; ovf_m[i] = 1'b0; done_m[i] = 1'b0; open_m[i] = 1'b0;
      end else begin
        done_m[i] = 1'b0;
        if (start) begin
          n_m[i] = 0; ovf_m[i] = 1'b0; open_m[i] = 1'b1;
        end
        if (in_valid && open_m[i]) begin
          if (n_m[i] < cfg_max(i)) begin
            bits_m[i][n_m[i]] = a;
            n_m[i] = n_m[i] + 1;
          end else begin
            ovf_m[i] = 1'b1;
          end
          if (in_last) begin
            open_m[i] = 1'b0; done_m[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Compare every checker against the model on each falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("dut%0d.rem", i), int'(dut_rem[i]), model_rem(i));
        checkOutput($sformatf("dut%0d.b", i), int'(dut_b[i]), int'(model_rem(i) == 0));
        checkOutput($sformatf("dut%0d.bit_cnt", i), int'(dut_cnt[i]), n_m[i]);
        checkOutput($sformatf("dut%0d.done", i), int'(dut_done[i]), int'(done_m[i]));
        checkOutput($sformatf("dut%0d.ovf", i), int'(dut_ovf[i]), int'(ovf_m[i]));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic v,
                               input logic d, input logic l);
    @(negedge clk);
    reset = r; start = s; in_valid = v; a = d; in_last = l;
    @(posedge clk);
    #1;
  endtask

  // Hand-computed values checked against both the DUT and the model
  task automatic expectLit(input string tag, input int i, input int r, input int c,
                           input int d, input int o);
    checkOutput($sformatf("%s dut%0d rem", tag, i), int'(dut_rem[i]), r);
    checkOutput($sformatf("%s dut%0d b", tag, i), int'(dut_b[i]), int'(r == 0));
    checkOutput($sformatf("%s dut%0d bit_cnt", tag, i), int'(dut_cnt[i]), c);
    checkOutput($sformatf("%s dut%0d done", tag, i), int'(dut_done[i]), d);
    checkOutput($sformatf("%s dut%0d ovf", tag, i), int'(dut_ovf[i]), o);
    checkOutput($sformatf("%s model%0d rem", tag, i), model_rem(i), r);
    checkOutput($sformatf("%s model%0d bit_cnt", tag, i), n_m[i], c);
  endtask

  initial begin
    int d1 [8] = '{1, 0, 1, 1, 0, 1, 0, 1};
    int r1 [8] = '{1, 1, 2, 1, 1, 0, 0, 2};
    int d2 [5] = '{1, 1, 0, 0, 1};
    int r2 [5] = '{1, 3, 1, 2, 0};
    int r3 [8] = '{1, 3, 0, 1, 3, 0, 1, 3};
    int r4 [4] = '{1, 0, 1, 0};

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    expectLit("reset", 0, 0, 0, 0, 0);
    expectLit("reset", 3, 0, 0, 0, 0);

    // LSB-first MOD 3, 0xAD
    applyStimulus(0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 1, d1[k][0], k == 7);
      expectLit($sformatf("lsb3 bit%0d", k), 0, r1[k], k + 1, int'(k == 7), 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    expectLit("lsb3 hold", 0, 2, 8, 0, 0);

    // MSB-first MOD 5, 25, first bit in the start cycle
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, k == 0, 1, d2[k][0], k == 4);
      expectLit($sformatf("msb5 bit%0d", k), 1, r2[k], k + 1, int'(k == 4), 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    expectLit("msb5 hold", 1, 0, 5, 0, 0);

    // LSB-first MOD 7, eight ones with gaps carrying a stray in_last
    applyStimulus(0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 1, 1, k == 7);
      expectLit($sformatf("lsb7 bit%0d", k), 2, r3[k], k + 1, int'(k == 7), 0);
      if (k == 2 || k == 4) begin
        applyStimulus(0, 0, 0, 1, 1);
        expectLit($sformatf("lsb7 gap%0d", k), 2, r3[k], k + 1, 0, 0);
      end
    end

    // MAX_BITS 4: fifth bit overflows but still ends the frame
    applyStimulus(0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 1, 1, k == 4);
      if (k < 4) expectLit($sformatf("max4 bit%0d", k), 3, r4[k], k + 1, 0, 0);
      else       expectLit("max4 over", 3, 0, 4, 1, 1);
    end

    // Reset mid-frame, then valid bits without start are ignored
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 1, 0);
    expectLit("midreset", 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 1);
    expectLit("after reset", 0, 0, 0, 0, 0);
    expectLit("after reset", 3, 0, 0, 0, 0);

    // One-bit frame, then start in the DONE cycle
    applyStimulus(0, 1, 1, 1, 1);
    expectLit("onebit", 0, 1, 1, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    expectLit("b2b bit0", 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 1);
    expectLit("b2b bit1", 0, 0, 2, 1, 0);

    // Random traffic against the model
    for (int k = 0; k < 2000; k++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 11) == 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
